cacheline_adapter: RTL

CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

---
 rtl/cacheline_adapter_pkg.sv | 17 +
 rtl/cacheline_adapter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/cacheline_adapter_pkg.sv
// Shared types and sizes for the cache line <-> burst memory adapter.
package cache_types;

  localparam int BEAT_W = 64;
  localparam int BEATS  = 4;
  localparam int LINE_W = 256;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_BURST = 3'd1,
    RD_REQ   = 3'd2,
    RD_WAIT  = 3'd3,
    RESP     = 3'd4,
    HOLD     = 3'd5
  } adapter_state_t;

endpackage

// File: rtl/cacheline_adapter.sv
// Cache line adapter: turns one 256-bit line fill or writeback into a
// 4 x 64-bit burst on the memory side, lowest beat first.
// Optional feature: define ADAPTER_PERF_EN to get saturating fill/writeback
// counters on perf_reads/perf_writes; otherwise both are tied to zero.
module cacheline_adapter
  import cache_types::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         dfp_addr,
  input  logic                dfp_read,
  input  logic                dfp_write,
  input  logic [LINE_W-1:0]   dfp_wdata,
  output logic [LINE_W-1:0]   dfp_rdata,
  output logic                dfp_resp,
  output logic [31:0]         bmem_addr,
  output logic                bmem_read,
  output logic                bmem_write,
  output logic [BEAT_W-1:0]   bmem_wdata,
  input  logic                bmem_ready,
  input  logic [31:0]         bmem_raddr,
  input  logic [BEAT_W-1:0]   bmem_rdata,
  input  logic                bmem_rvalid,
  output logic [31:0]         perf_reads,
  output logic [31:0]         perf_writes
);

  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  adapter_state_t      state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [31:0]         addr_q, addr_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                is_read_q, is_read_d;

  // Bit offset of the current beat inside the line buffer.
  logic [7:0]          beat_lsb;
  assign beat_lsb = {cnt_q, 6'd0};

  // Returning beats are matched purely by order, so the beat address is not needed.
  logic                unused_raddr;
  assign unused_raddr = ^bmem_raddr;

  // State and datapath registers; reset clears everything, even mid-burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      addr_q    <= '0;
      line_q    <= '0;
      is_read_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      line_q    <= line_d;
      is_read_q <= is_read_d;
    end
  end

  // Next-state logic and all outputs; memory-side outputs are zero outside their states.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    line_d     = line_q;
    is_read_d  = is_read_q;
    bmem_addr  = '0;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_wdata = '0;
    dfp_resp   = 1'b0;
    dfp_rdata  = '0;

    case (state_q)
      IDLE: begin
        // A writeback wins over a fill so the dirty victim leaves first.
        if (dfp_write) begin
          addr_d    = dfp_addr;
          line_d    = dfp_wdata;
          is_read_d = 1'b0;
          cnt_d     = 2'd0;
          state_d   = WR_BURST;
        end else if (dfp_read) begin
          addr_d    = dfp_addr;
          line_d    = '0;
          is_read_d = 1'b1;
          cnt_d     = 2'd0;
          state_d   = RD_REQ;
        end
      end

      WR_BURST: begin
        bmem_write = 1'b1;
        bmem_addr  = addr_q;
        bmem_wdata = line_q[beat_lsb +: BEAT_W];
        if (bmem_ready) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == LAST_BEAT) begin
            state_d = RESP;
          end
        end
      end

      RD_REQ: begin
        bmem_read = 1'b1;
        bmem_addr = addr_q;
        if (bmem_ready) begin
          cnt_d   = 2'd0;
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
        if (bmem_rvalid) begin
          line_d[beat_lsb +: BEAT_W] = bmem_rdata;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == LAST_BEAT) begin
            state_d = RESP;
          end
        end
      end

      RESP: begin
        dfp_resp = 1'b1;
        if (is_read_q) begin
          dfp_rdata = line_q;
        end
        state_d = HOLD;
      end

      // The cache only drops its request after seeing resp, so skip one cycle.
      HOLD: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef ADAPTER_PERF_EN
  logic [31:0] perf_reads_q;
  logic [31:0] perf_writes_q;

  // Count completed fills and writebacks, sticking at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_reads_q  <= '0;
      perf_writes_q <= '0;
    end else if (state_q == RESP) begin
      if (is_read_q && (perf_reads_q != 32'hFFFF_FFFF)) begin
        perf_reads_q <= perf_reads_q + 32'd1;
      end
      if (!is_read_q && (perf_writes_q != 32'hFFFF_FFFF)) begin
        perf_writes_q <= perf_writes_q + 32'd1;
      end
    end
  end

  assign perf_reads  = perf_reads_q;
  assign perf_writes = perf_writes_q;
`else
  assign perf_reads  = '0;
  assign perf_writes = '0;
`endif

endmodule
